mem_burst_responder: RTL and testbench
======================================

# mem_burst_responder

Memory-side responder for cache line refills and write-backs. Accepts one line-aligned request at a time from the cache controller, waits a programmable access latency, then streams a full line as one word per cycle: out of a word array for refills, or into the array for write-backs. It is the backing-store end of the cache line interface and serves as both the simulation main memory and the synthesizable on-chip RAM model.

## Interface
- OFFSET_WIDTH, default `CACHE_B`: byte-offset bits per line.
- LINE_SIZE, default 2**(`CACHE_B - 2): words per line, which is the burst length.
- MEM_WORDS, default 1024: array depth in 32-bit words; must be a power of two and at least LINE_SIZE.
- LATENCY, default 2: wait cycles between accept and first beat; range 0..15.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  1  request valid.
- we_i  input  1  1 = write-back (cache to memory), 0 = refill (memory to cache).
- addr_i  input  32  byte address; the low OFFSET_WIDTH bits are ignored.
- wdata_i  input  32  write-back data; sampled on beat cycles when we_i was set at accept.
- ready_o  output  1  responder idle; a request is accepted when req_i && ready_o.
- beat_o  output  1  a data beat occurs this cycle.
- idx_o  output  OFFSET_WIDTH-2  word index of the current beat within the line.
- rdata_o  output  32  refill data; valid when beat_o is high on a refill.
- done_o  output  1  high on the final beat cycle of a burst.
- err_o  output  1  address-error pulse; present only with MEM_ERR_EN.

## Operation
- FSM states are IDLE, WAIT and BURST.
- IDLE:
  - ready_o=1.
  - On req_i: latch we_i and the line base word address ((addr_i>>2) with the low OFFSET_WIDTH-2 bits cleared, modulo MEM_WORDS).
  - Clear the latency counter and beat index.
  - Next state is WAIT if LATENCY>0, otherwise BURST.
- WAIT:
  - ready_o=0.
  - The counter increments each cycle. Go to BURST when counter==LATENCY-1.
  - req_i is ignored.
- BURST:
  - beat_o=1 and idx_o=beat index.
  - Refill: rdata_o = mem[base+idx], a combinational read.
  - Write-back: mem[base+idx] <= wdata_i at the clock edge.
  - The index increments each cycle.
  - On idx==LINE_SIZE-1: done_o=1, next state IDLE, index wraps to 0.
- The cache side cannot stall a burst. Every beat completes in one cycle.
- Word addressing wraps modulo MEM_WORDS. base+idx never crosses a line because base is line-aligned.
- Outside BURST: beat_o=0, done_o=0, and rdata_o=0 (rdata_o is gated, not stale).
- Memory contents are not reset. Simulation preload comes from the bench.

## Timing
- Cycle 0 is the cycle in which req_i && ready_o.
- WAIT occupies cycles 1..L. Beats occupy cycles L+1..L+LINE_SIZE. done_o is high in cycle L+LINE_SIZE.
- ready_o returns high in cycle L+LINE_SIZE+1. Back-to-back accept is possible in that cycle.
- A request presented on the same cycle as done_o is not accepted, because ready_o=0 then.
- Total occupancy per request is 1+L+LINE_SIZE cycles.
- Data written on a write-back beat is visible to any later refill. No read-during-write hazard exists, because only one request is in flight.
- Reset:
  - rst_ni low forces IDLE immediately, asynchronously.
  - Reset values: ready_o=1, beat_o=0, idx_o=0, rdata_o=0, done_o=0, err_o=0; counter and index are 0.
  - Reset mid-burst aborts the burst. Beats already written remain in memory, and no done_o is issued.

## Configuration
- MEM_ERR_EN defined:
  - An address with (addr_i>>2) >= MEM_WORDS is flagged at accept.
  - The FSM skips WAIT and BURST and stays IDLE.
  - err_o pulses high for the cycle after accept, and ready_o is 0 during that cycle.
  - No beats occur and memory is untouched.
- MEM_ERR_EN undefined:
  - err_o is absent.
  - Out-of-range addresses wrap modulo MEM_WORDS.

## Test plan
Configuration for all scenarios: CACHE_B=4 (LINE_SIZE=4), LATENCY=2, MEM_WORDS=256.
- Reset mid-WAIT: pulse rst_ni low during cycle 1 -> outputs return to reset values at once, ready_o=1; the next request is served normally.
- Refill: preload mem[8..11]=A0..A3; req with we_i=0, addr_i=0x20 -> beats in cycles 3..6 with idx_o 0..3, rdata_o A0..A3; done_o in cycle 6; ready_o in cycle 7.
- Write-back then refill:
  - Write-back to addr 0x44 with wdata_i D0..D3 -> mem[16..19]=D0..D3.
  - Refill of 0x40 accepted in the first ready cycle -> D0..D3 returned.
  - Back-to-back accept is verified.
- Busy ignore: hold req_i high during WAIT and BURST with a different address -> single burst only; the second request is accepted only in cycle 7.
- LATENCY=0: refill 0x00 -> beats in cycles 1..4, done_o in cycle 4.
- Out-of-range address 0x400 (word 256):
  - MEM_ERR_EN defined -> err_o in cycle 1, no beat_o, memory unchanged.
  - MEM_ERR_EN undefined -> wraps, returning mem[0..3].

Source files
------------

// File: rtl/mem_burst_responder.sv
// Line-burst memory responder: accepts one line request, waits LATENCY cycles,
// then streams LINE_SIZE words out of (refill) or into (write-back) the array.
// Optional address-range error reporting is enabled by defining MEM_ERR_EN.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_burst_responder #(
  parameter int unsigned OFFSET_WIDTH = `CACHE_B,
  parameter int unsigned LINE_SIZE    = 2 ** (`CACHE_B - 2),
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned LATENCY      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [31:0]             addr_i,
  input  logic [31:0]             wdata_i,
  output logic                    ready_o,
  output logic                    beat_o,
  output logic [OFFSET_WIDTH-3:0] idx_o,
  output logic [31:0]             rdata_o,
  output logic                    done_o
`ifdef MEM_ERR_EN
  ,
  output logic                    err_o
`endif
);

  localparam int unsigned IDX_W = OFFSET_WIDTH - 2;
  localparam int unsigned AW    = $clog2(MEM_WORDS);

  localparam logic [3:0]       LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [AW-1:0]    base_q, base_d;
  logic             err_q, err_d;

  logic [31:0]      mem [MEM_WORDS];
  logic [AW-1:0]    word_addr;
  logic [AW-1:0]    mem_addr;
  logic             accept;
  logic             addr_oor;

  // Word address wraps modulo MEM_WORDS; the line offset bits are dropped.
  assign word_addr = addr_i[AW+1:2];
  assign mem_addr  = base_q | AW'(idx_q);

`ifdef MEM_ERR_EN
  assign addr_oor = |addr_i[31:AW+2];
  logic unused_addr;
  assign unused_addr = ^{addr_i[IDX_W+1:0]};
`else
  assign addr_oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[IDX_W+1:0]};
`endif

  assign accept = req_i && (state_q == IDLE) && !err_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    base_d  = base_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          idx_d = '0;
          if (addr_oor) begin
            err_d = 1'b1;
          end else begin
            we_d    = we_i;
            base_d  = {word_addr[AW-1:IDX_W], {IDX_W{1'b0}}};
            state_d = (LATENCY == 0) ? BURST : WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_WAIT) state_d = BURST;
      end
      BURST: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o = (state_q == IDLE) && !err_q;
    beat_o  = (state_q == BURST);
    idx_o   = idx_q;
    done_o  = beat_o && (idx_q == LAST_IDX);
    rdata_o = beat_o ? mem[mem_addr] : '0;
  end

`ifdef MEM_ERR_EN
  assign err_o = err_q;
`endif

  // Storage array, deliberately left without reset
  always_ff @(posedge clk_i) begin
    if (beat_o && we_q) mem[mem_addr] <= wdata_i;
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder: directed scenarios plus random
// refills/write-backs checked against an array model and burst timing formula.
module tb_mem_burst_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic        sel;

  logic        ready_a, beat_a, done_a;
  logic [1:0]  idx_a;
  logic [31:0] rdata_a;
  logic        ready_b, beat_b, done_b;
  logic [1:0]  idx_b;
  logic [31:0] rdata_b;
  logic        err_a = 1'b0;
  logic        err_b = 1'b0;
  logic        req_a, req_b;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] mdl [2][256];
  logic [31:0] wd  [4];

  assign req_a = req_i && !sel;
  assign req_b = req_i && sel;

  always #5 clk_i = ~clk_i;

  mem_burst_responder #(
    .OFFSET_WIDTH(4), .LINE_SIZE(4), .MEM_WORDS(256), .LATENCY(2)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_a), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_a), .beat_o(beat_a),
    .idx_o(idx_a), .rdata_o(rdata_a), .done_o(done_a)
`ifdef MEM_ERR_EN
    , .err_o(err_a)
`endif
  );

  mem_burst_responder #(
    .OFFSET_WIDTH(4), .LINE_SIZE(4), .MEM_WORDS(256), .LATENCY(0)
  ) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_b), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_b), .beat_o(beat_b),
    .idx_o(idx_b), .rdata_o(rdata_b), .done_o(done_b)
`ifdef MEM_ERR_EN
    , .err_o(err_b)
`endif
  );

  logic        ready_s, beat_s, done_s, err_s;
  logic [1:0]  idx_s;
  logic [31:0] rdata_s;
  assign ready_s = sel ? ready_b : ready_a;
  assign beat_s  = sel ? beat_b  : beat_a;
  assign done_s  = sel ? done_b  : done_a;
  assign idx_s   = sel ? idx_b   : idx_a;
  assign rdata_s = sel ? rdata_b : rdata_a;
  assign err_s   = sel ? err_b   : err_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready_s), 32'd1);
    chk({tag, "_beat"},  32'(beat_s),  32'd0);
    chk({tag, "_idx"},   32'(idx_s),   32'd0);
    chk({tag, "_rdata"}, rdata_s,      32'd0);
    chk({tag, "_done"},  32'(done_s),  32'd0);
    chk({tag, "_err"},   32'(err_s),   32'd0);
  endtask

  // Called at the start of a cycle in which the selected DUT should be ready.
  // Returns at the start of the cycle in which it is ready again.
  task automatic do_req(input bit we, input logic [31:0] addr, input bit hold,
                        input logic [31:0] addr2);
    int lat;
    int base;
    bit oor;
    bit bt;
    int k;
    lat  = sel ? 0 : 2;
    base = int'(((addr >> 2) & ~32'd3) % 256);
    oor  = (addr >> 2) >= 256;
    chk("ready_at_req", 32'(ready_s), 32'd1);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = $urandom;
`ifdef MEM_ERR_EN
    if (oor) begin
      @(posedge clk_i); #1;
      req_i = 1'b0;
      chk("oor_err",   32'(err_s),   32'd1);
      chk("oor_ready", 32'(ready_s), 32'd0);
      chk("oor_beat",  32'(beat_s),  32'd0);
      @(posedge clk_i); #1;
      chk("oor_err_end",   32'(err_s),   32'd0);
      chk("oor_ready_end", 32'(ready_s), 32'd1);
      chk("oor_beat_end",  32'(beat_s),  32'd0);
      return;
    end
`else
    if (oor) base = base;
`endif
    for (int c = 1; c <= lat + 5; c++) begin
      @(posedge clk_i); #1;
      if (hold) begin
        addr_i = addr2;
        we_i   = 1'b0;
      end else begin
        req_i = 1'b0;
      end
      bt = (c >= lat + 1) && (c <= lat + 4);
      k  = c - lat - 1;
      wdata_i = (bt && we) ? wd[k] : $urandom;
      chk("beat",  32'(beat_s),  32'(bt));
      chk("done",  32'(done_s),  32'(c == lat + 4));
      chk("ready", 32'(ready_s), 32'(c == lat + 5));
      chk("err",   32'(err_s),   32'd0);
      if (bt) chk("idx", 32'(idx_s), 32'(k));
      if (!bt) chk("rdata_gated", rdata_s, 32'd0);
      else if (!we) chk("rdata", rdata_s, mdl[sel][base + k]);
      if (bt && we) mdl[sel][base + k] = wd[k];
    end
  endtask

  task automatic rand_wd();
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; sel = 1'b0;
    #12;
    chk_reset_vals("rst_a");
    sel = 1'b1;
    chk_reset_vals("rst_b");
    sel = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Preload the whole array so every later refill has a known expectation
    for (int ln = 0; ln < 64; ln++) begin
      rand_wd();
      do_req(1'b1, 32'(ln * 16), 1'b0, 32'd0);
    end

    // Refill of a known line
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0A0_0000 + 32'(i);
    do_req(1'b1, 32'h20, 1'b0, 32'd0);
    do_req(1'b0, 32'h20, 1'b0, 32'd0);

    // Write-back to an unaligned address, then back-to-back refill of the line
    for (int i = 0; i < 4; i++) wd[i] = 32'hD0D0_0000 + 32'(i);
    do_req(1'b1, 32'h44, 1'b0, 32'd0);
    do_req(1'b0, 32'h40, 1'b0, 32'd0);
    chk("wb_word16", mdl[0][16], 32'hD0D0_0000);

    // Request held high while busy is accepted only once the burst ends
    do_req(1'b0, 32'h20, 1'b1, 32'h80);
    do_req(1'b0, 32'h80, 1'b0, 32'd0);

    // Reset during WAIT
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    chk("wait_ready", 32'(ready_s), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("rst_wait");
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_beat", 32'(beat_s), 32'd0);
    do_req(1'b0, 32'h20, 1'b0, 32'd0);

    // Out-of-range address: error pulse with MEM_ERR_EN, wrap otherwise
    do_req(1'b0, 32'h400, 1'b0, 32'd0);
    rand_wd();
    do_req(1'b1, 32'h404, 1'b0, 32'd0);
    do_req(1'b0, 32'h00, 1'b0, 32'd0);

    // Random traffic over in-range and out-of-range addresses
    for (int n = 0; n < 60; n++) begin
      rand_wd();
      do_req(1'($urandom_range(0, 1)), $urandom & 32'h7FF, 1'b0, 32'd0);
    end

    // Zero-latency instance
    sel = 1'b1;
    rand_wd();
    do_req(1'b1, 32'h00, 1'b0, 32'd0);
    do_req(1'b0, 32'h00, 1'b0, 32'd0);
    rand_wd();
    do_req(1'b1, 32'h3C, 1'b0, 32'd0);
    do_req(1'b0, 32'h30, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
